// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants for register-file sizing and the hardwired zero register.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Write-port and dual read-port bundle between the datapath and the register file.
interface reg_file_2r1w_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [15:0]       wr_cnt;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, wr_cnt
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, wr_cnt
  );

endinterface

// File: rtl/reg_wr_decoder.sv
// One-hot write-enable decoder; entry 0 is never enabled so $0 stays zero.
module reg_wr_decoder #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   i_we,
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [(1<<ADDR_W)-1:0] o_en
);

  always_comb begin
    o_en = '0;
    if (i_we) begin
      o_en[i_addr] = 1'b1;
    end
    o_en[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file with optional same-cycle write forwarding and a
// saturating committed-write counter.
module reg_file_2r1w
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input logic            clk,
  input logic            rst_n,
  reg_file_2r1w_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [15:0]       r_wr_cnt;
  logic [DEPTH-1:0]  w_en;
  logic              w_commit;
  logic              w_fwd_a;
  logic              w_fwd_b;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;

  reg_wr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wr_decoder (
    .i_we   (bus.we),
    .i_addr (bus.waddr),
    .o_en   (w_en)
  );

  assign w_commit = |w_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_en[i]) begin
          r_regs[i] <= bus.wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
    end else if (w_commit && (r_wr_cnt != 16'hFFFF)) begin
      r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  // Forwarding only fires for a real commit, so a write aimed at $0 never leaks.
  assign w_fwd_a = (BYPASS != 0) && w_commit && (bus.waddr == bus.raddr_a);
  assign w_fwd_b = (BYPASS != 0) && w_commit && (bus.waddr == bus.raddr_b);

  always_comb begin
    w_rdata_a = r_regs[bus.raddr_a];
    if (w_fwd_a) begin
      w_rdata_a = bus.wdata;
    end
    if (bus.raddr_a == '0) begin
      w_rdata_a = '0;
    end
  end

  always_comb begin
    w_rdata_b = r_regs[bus.raddr_b];
    if (w_fwd_b) begin
      w_rdata_b = bus.wdata;
    end
    if (bus.raddr_b == '0) begin
      w_rdata_b = '0;
    end
  end

  assign bus.rdata_a = w_rdata_a;
  assign bus.rdata_b = w_rdata_b;
  assign bus.wr_cnt  = r_wr_cnt;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench driving a forwarding and a non-forwarding register file in lockstep.
module tb_reg_file_2r1w;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) if_byp ();
  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) if_nob ();

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_byp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_byp)
  );

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nob (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_nob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(if_byp.we) && !$isunknown(if_nob.we))
        else $error("we is X while out of reset");
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic [4:0] ra, input logic [4:0] rb);
    if_byp.we = we;  if_byp.waddr = waddr;  if_byp.wdata = wdata;
    if_byp.raddr_a = ra;  if_byp.raddr_b = rb;
    if_nob.we = we;  if_nob.waddr = waddr;  if_nob.wdata = wdata;
    if_nob.raddr_a = ra;  if_nob.raddr_b = rb;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);

    // Reset pulse with no clock edge in between.
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rd_a_byp", if_byp.rdata_a, 32'h0);
    check_eq("rst_rd_b_byp", if_byp.rdata_b, 32'h0);
    check_eq("rst_rd_a_nob", if_nob.rdata_a, 32'h0);
    check_eq("rst_cnt",      {16'h0, if_byp.wr_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1;
    check_eq("wr5_rd_byp", if_byp.rdata_a, 32'hDEADBEEF);
    check_eq("wr5_rd_nob", if_nob.rdata_a, 32'hDEADBEEF);
    check_eq("wr5_cnt",    {16'h0, if_byp.wr_cnt}, 32'd1);

    // Write to $0 is discarded and not counted.
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd5, 5'd0);
    #1;
    check_eq("z0_fwd_byp", if_byp.rdata_b, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1;
    check_eq("z0_rd_byp", if_byp.rdata_b, 32'h0);
    check_eq("z0_rd_nob", if_nob.rdata_b, 32'h0);
    check_eq("z0_cnt",    {16'h0, if_nob.wr_cnt}, 32'd1);

    // Same-cycle forwarding on both ports.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9);
    #1;
    check_eq("fwd_a_byp", if_byp.rdata_a, 32'h12345678);
    check_eq("fwd_b_byp", if_byp.rdata_b, 32'h12345678);
    check_eq("old_a_nob", if_nob.rdata_a, 32'h0);
    check_eq("old_b_nob", if_nob.rdata_b, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    check_eq("new_a_nob", if_nob.rdata_a, 32'h12345678);
    check_eq("new_b_nob", if_nob.rdata_b, 32'h12345678);
    check_eq("fwd_cnt",   {16'h0, if_byp.wr_cnt}, 32'd2);

    // Forward on one port only; the other reads stored data.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'hCAFE0009, 5'd9, 5'd5);
    #1;
    check_eq("fwd1_a_byp", if_byp.rdata_a, 32'hCAFE0009);
    check_eq("fwd1_b_byp", if_byp.rdata_b, 32'hDEADBEEF);
    check_eq("fwd1_a_nob", if_nob.rdata_a, 32'h12345678);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
    #1;
    check_eq("fwd1_cnt", {16'h0, if_nob.wr_cnt}, 32'd3);

    // Reset between edges clears state at once; a write held across reset is lost.
    @(negedge clk);
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
    #1;
    check_eq("r7_pre_rst", if_nob.rdata_a, 32'hA5A5A5A5);
    drive(1'b1, 5'd3, 32'h33333333, 5'd7, 5'd5);
    #1 rst_n = 1'b0;
    #1;
    check_eq("r7_rst_byp", if_byp.rdata_a, 32'h0);
    check_eq("r7_rst_nob", if_nob.rdata_a, 32'h0);
    check_eq("r5_rst_nob", if_nob.rdata_b, 32'h0);
    check_eq("rst_cnt2",   {16'h0, if_nob.wr_cnt}, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
    rst_n = 1'b1;
    #1;
    check_eq("lost_wr3", if_nob.rdata_a, 32'h0);
    drive(1'b1, 5'd7, 32'h00000001, 5'd3, 5'd7);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
    #1;
    check_eq("r7_post_byp", if_byp.rdata_b, 32'h1);
    check_eq("r7_post_nob", if_nob.rdata_b, 32'h1);
    check_eq("post_cnt",    {16'h0, if_byp.wr_cnt}, 32'd1);

    // Saturation: 1 prior write + 65536 writes to reg31.
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd31, i[31:0], 5'd31, 5'd7);
      if (i == 65534) begin
        #1;
        check_eq("cnt_at_max", {16'h0, if_byp.wr_cnt}, 32'h0000FFFF);
      end
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd7);
    #1;
    check_eq("sat_cnt_byp", {16'h0, if_byp.wr_cnt}, 32'h0000FFFF);
    check_eq("sat_cnt_nob", {16'h0, if_nob.wr_cnt}, 32'h0000FFFF);
    check_eq("sat_r31_nob", if_nob.rdata_a, 32'h0000FFFF);
    check_eq("sat_r7_byp",  if_byp.rdata_b, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
